// File: rtl/id_ex_operand_stage_if.sv
// Signal bundle between decode, the ID/EX operand stage and the ALU.
// The master drives decode fields and forwarding sources; the slave is the stage itself.
interface id_ex_operand_stage_if;
    logic        Stall;
    logic        Flush;
    logic        InValid;
    logic [3:0]  InALUControl;
    logic [4:0]  InRs;
    logic [4:0]  InRt;
    logic [31:0] InRsData;
    logic [31:0] InRtData;
    logic [31:0] InImm;
    logic [4:0]  InShamt;
    logic        InALUSrc;
    logic        InShiftVar;
    logic        InMemRead;
    logic        InRegWrite;
    logic [4:0]  InWriteReg;
    logic        ExMemRegWrite;
    logic [4:0]  ExMemWriteReg;
    logic [31:0] ExMemALUResult;
    logic        MemWbRegWrite;
    logic [4:0]  MemWbWriteReg;
    logic [31:0] MemWbWriteData;
    logic [3:0]  ALUControl;
    logic [31:0] A;
    logic [31:0] B;
    logic [31:0] StoreData;
    logic        OutValid;
    logic        OutMemRead;
    logic        OutRegWrite;
    logic [4:0]  OutWriteReg;
    logic        LoadUseStall;

    modport master (
        output Stall, Flush, InValid, InALUControl, InRs, InRt, InRsData, InRtData, InImm,
               InShamt, InALUSrc, InShiftVar, InMemRead, InRegWrite, InWriteReg,
               ExMemRegWrite, ExMemWriteReg, ExMemALUResult,
               MemWbRegWrite, MemWbWriteReg, MemWbWriteData,
        input  ALUControl, A, B, StoreData, OutValid, OutMemRead, OutRegWrite, OutWriteReg,
               LoadUseStall
    );

    modport slave (
        input  Stall, Flush, InValid, InALUControl, InRs, InRt, InRsData, InRtData, InImm,
               InShamt, InALUSrc, InShiftVar, InMemRead, InRegWrite, InWriteReg,
               ExMemRegWrite, ExMemWriteReg, ExMemALUResult,
               MemWbRegWrite, MemWbWriteReg, MemWbWriteData,
        output ALUControl, A, B, StoreData, OutValid, OutMemRead, OutRegWrite, OutWriteReg,
               LoadUseStall
    );
endinterface

// File: rtl/id_ex_operand_stage.sv
// ID/EX register with operand forwarding, shift/immediate routing and load-use bubble insertion.
// Define SHIFT_VAR_EN to take the shift amount from rs when InShiftVar is set (sllv/srlv).
module id_ex_operand_stage (
    input logic                  Clk,
    input logic                  Reset,
    id_ex_operand_stage_if.slave bus
);
    typedef struct packed {
        logic        valid;
        logic [3:0]  alu_ctrl;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [31:0] rs_data;
        logic [31:0] rt_data;
        logic [31:0] imm;
        logic [4:0]  shamt;
        logic        alu_src;
`ifdef SHIFT_VAR_EN
        logic        shift_var;
`endif
        logic        mem_read;
        logic        reg_write;
        logic [4:0]  write_reg;
    } stage_t;

    stage_t      stage_q, stage_d, in_fields;
    logic        load_use;
    logic        is_shift;
    logic [4:0]  shift_amt;
    logic [31:0] fwd_rs, fwd_rt;

    always_comb begin
        in_fields           = '0;
        in_fields.valid     = bus.InValid;
        in_fields.alu_ctrl  = bus.InALUControl;
        in_fields.rs        = bus.InRs;
        in_fields.rt        = bus.InRt;
        in_fields.rs_data   = bus.InRsData;
        in_fields.rt_data   = bus.InRtData;
        in_fields.imm       = bus.InImm;
        in_fields.shamt     = bus.InShamt;
        in_fields.alu_src   = bus.InALUSrc;
`ifdef SHIFT_VAR_EN
        in_fields.shift_var = bus.InShiftVar;
`endif
        in_fields.mem_read  = bus.InMemRead;
        in_fields.reg_write = bus.InRegWrite;
        in_fields.write_reg = bus.InWriteReg;
    end

`ifndef SHIFT_VAR_EN
    logic unused_shift_var;
    assign unused_shift_var = bus.InShiftVar;
`endif

    // A load in EX whose destination feeds the instruction now in decode.
    assign load_use = stage_q.valid && stage_q.mem_read && bus.InValid &&
                      (stage_q.write_reg != 5'd0) &&
                      ((stage_q.write_reg == bus.InRs) || (stage_q.write_reg == bus.InRt));

    always_comb begin
        stage_d = stage_q;
        if (bus.Flush) begin
            stage_d = '0;
        end else if (!bus.Stall) begin
            stage_d = load_use ? '0 : in_fields;
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            stage_q <= '0;
        end else begin
            stage_q <= stage_d;
        end
    end

    // EX/MEM is younger than MEM/WB, so it wins when both match.
    always_comb begin
        fwd_rs = stage_q.rs_data;
        if (bus.ExMemRegWrite && (bus.ExMemWriteReg != 5'd0) &&
            (bus.ExMemWriteReg == stage_q.rs)) begin
            fwd_rs = bus.ExMemALUResult;
        end else if (bus.MemWbRegWrite && (bus.MemWbWriteReg != 5'd0) &&
                     (bus.MemWbWriteReg == stage_q.rs)) begin
            fwd_rs = bus.MemWbWriteData;
        end
        fwd_rt = stage_q.rt_data;
        if (bus.ExMemRegWrite && (bus.ExMemWriteReg != 5'd0) &&
            (bus.ExMemWriteReg == stage_q.rt)) begin
            fwd_rt = bus.ExMemALUResult;
        end else if (bus.MemWbRegWrite && (bus.MemWbWriteReg != 5'd0) &&
                     (bus.MemWbWriteReg == stage_q.rt)) begin
            fwd_rt = bus.MemWbWriteData;
        end
    end

    always_comb begin
        is_shift  = (stage_q.alu_ctrl == 4'b0110) || (stage_q.alu_ctrl == 4'b0111);
        shift_amt = stage_q.shamt;
`ifdef SHIFT_VAR_EN
        if (stage_q.shift_var) begin
            shift_amt = fwd_rs[4:0];
        end
`endif
    end

    always_comb begin
        bus.ALUControl = stage_q.alu_ctrl;
        if (is_shift) begin
            bus.A = fwd_rt;
            bus.B = {27'd0, shift_amt};
        end else begin
            bus.A = fwd_rs;
            bus.B = stage_q.alu_src ? stage_q.imm : fwd_rt;
        end
        bus.StoreData    = fwd_rt;
        bus.OutValid     = stage_q.valid;
        bus.OutMemRead   = stage_q.valid & stage_q.mem_read;
        bus.OutRegWrite  = stage_q.valid & stage_q.reg_write;
        bus.OutWriteReg  = stage_q.write_reg;
        bus.LoadUseStall = load_use;
    end
endmodule

// File: tb/tb_id_ex_operand_stage.sv
// Directed bench for id_ex_operand_stage: forwarding, shift routing, load-use and control priority.
module tb_id_ex_operand_stage;
    logic clk = 1'b0;
    logic rst;
    int   n_checks = 0;
    int   n_fails  = 0;

    id_ex_operand_stage_if bus ();

    id_ex_operand_stage dut (
        .Clk   (clk),
        .Reset (rst),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        assert (got === exp) else begin
            n_fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic clear_in();
        bus.Stall = 0; bus.Flush = 0; bus.InValid = 0; bus.InALUControl = 4'd0;
        bus.InRs = 5'd0; bus.InRt = 5'd0; bus.InRsData = 32'd0; bus.InRtData = 32'd0;
        bus.InImm = 32'd0; bus.InShamt = 5'd0; bus.InALUSrc = 0; bus.InShiftVar = 0;
        bus.InMemRead = 0; bus.InRegWrite = 0; bus.InWriteReg = 5'd0;
        bus.ExMemRegWrite = 0; bus.ExMemWriteReg = 5'd0; bus.ExMemALUResult = 32'd0;
        bus.MemWbRegWrite = 0; bus.MemWbWriteReg = 5'd0; bus.MemWbWriteData = 32'd0;
    endtask

    task automatic issue_lw(input logic [4:0] dst);
        clear_in();
        bus.InValid = 1; bus.InMemRead = 1; bus.InRegWrite = 1; bus.InWriteReg = dst;
        bus.InALUSrc = 1; bus.InImm = 32'd4;
        tick();
    endtask

    initial begin
        clear_in();
        rst = 1;
        tick();
        tick();
        check("rst_aluctl", {28'd0, bus.ALUControl}, 32'd0);
        check("rst_a", bus.A, 32'd0);
        check("rst_b", bus.B, 32'd0);
        check("rst_store", bus.StoreData, 32'd0);
        check("rst_valid", {31'd0, bus.OutValid}, 32'd0);
        check("rst_wreg", {27'd0, bus.OutWriteReg}, 32'd0);
        check("rst_lus", {31'd0, bus.LoadUseStall}, 32'd0);
        rst = 0;

        // Plain add
        bus.InValid = 1; bus.InRs = 5'd1; bus.InRt = 5'd2; bus.InRsData = 32'd1;
        bus.InRtData = 32'd1; bus.InRegWrite = 1; bus.InWriteReg = 5'd3;
        tick();
        check("add_aluctl", {28'd0, bus.ALUControl}, 32'd0);
        check("add_a", bus.A, 32'd1);
        check("add_b", bus.B, 32'd1);
        check("add_valid", {31'd0, bus.OutValid}, 32'd1);
        check("add_regw", {31'd0, bus.OutRegWrite}, 32'd1);
        check("add_wreg", {27'd0, bus.OutWriteReg}, 32'd3);

        // Immediate operand
        clear_in();
        bus.InValid = 1; bus.InALUControl = 4'b0011; bus.InRs = 5'd1; bus.InRt = 5'd2;
        bus.InRsData = 32'd5; bus.InRtData = 32'd7; bus.InImm = 32'h100; bus.InALUSrc = 1;
        tick();
        check("ori_aluctl", {28'd0, bus.ALUControl}, 32'd3);
        check("ori_a", bus.A, 32'd5);
        check("ori_b", bus.B, 32'h100);
        check("ori_store", bus.StoreData, 32'd7);

        // Forwarding priority
        clear_in();
        bus.InValid = 1; bus.InRs = 5'd5; bus.InRsData = 32'd3; bus.InRt = 5'd6;
        bus.InRtData = 32'd4;
        tick();
        bus.ExMemRegWrite = 1; bus.ExMemWriteReg = 5'd5; bus.ExMemALUResult = 32'h10;
        bus.MemWbRegWrite = 1; bus.MemWbWriteReg = 5'd5; bus.MemWbWriteData = 32'h20;
        #1;
        check("fwd_exmem", bus.A, 32'h10);
        check("fwd_exmem_b", bus.B, 32'd4);
        bus.ExMemRegWrite = 0;
        #1;
        check("fwd_memwb", bus.A, 32'h20);
        bus.MemWbWriteReg = 5'd6;
        #1;
        check("fwd_none_a", bus.A, 32'd3);
        check("fwd_memwb_rt", bus.B, 32'h20);
        check("fwd_store", bus.StoreData, 32'h20);

        // Register 0 is never forwarded
        clear_in();
        bus.InValid = 1; bus.InRs = 5'd0; bus.InRsData = 32'h33;
        tick();
        bus.ExMemRegWrite = 1; bus.ExMemWriteReg = 5'd0; bus.ExMemALUResult = 32'h10;
        bus.MemWbRegWrite = 1; bus.MemWbWriteReg = 5'd0; bus.MemWbWriteData = 32'h20;
        #1;
        check("fwd_r0", bus.A, 32'h33);

        // Shift routing: srl
        clear_in();
        bus.InValid = 1; bus.InALUControl = 4'b0111; bus.InRs = 5'd4; bus.InRsData = 32'h23;
        bus.InRt = 5'd2; bus.InRtData = 32'd2; bus.InShamt = 5'd1; bus.InShiftVar = 0;
        tick();
        check("srl_a", bus.A, 32'd2);
        check("srl_b", bus.B, 32'd1);
        bus.InShiftVar = 1;
        tick();
        check("srlv_a", bus.A, 32'd2);
`ifdef SHIFT_VAR_EN
        check("srlv_b", bus.B, 32'd3);
`else
        check("srlv_b_ignored", bus.B, 32'd1);
`endif

        // Load-use: lw r8 then consumer of r8
        issue_lw(5'd8);
        check("lw_memrd", {31'd0, bus.OutMemRead}, 32'd1);
        clear_in();
        bus.InValid = 1; bus.InRs = 5'd1; bus.InRt = 5'd8; bus.InRsData = 32'd5;
        bus.InRegWrite = 1; bus.InWriteReg = 5'd9;
        #1;
        check("lu_stall", {31'd0, bus.LoadUseStall}, 32'd1);
        tick();
        check("lu_bub_valid", {31'd0, bus.OutValid}, 32'd0);
        check("lu_bub_regw", {31'd0, bus.OutRegWrite}, 32'd0);
        check("lu_bub_stall", {31'd0, bus.LoadUseStall}, 32'd0);
        check("lu_bub_a", bus.A, 32'd0);
        tick();
        check("lu_after_valid", {31'd0, bus.OutValid}, 32'd1);
        check("lu_after_a", bus.A, 32'd5);

        // Load to r0 never stalls
        issue_lw(5'd0);
        clear_in();
        bus.InValid = 1; bus.InRs = 5'd0; bus.InRt = 5'd0;
        #1;
        check("lu_r0", {31'd0, bus.LoadUseStall}, 32'd0);

        // Hazard while stalled: hold, bubble on first free edge
        issue_lw(5'd8);
        clear_in();
        bus.InValid = 1; bus.InRs = 5'd8; bus.Stall = 1;
        #1;
        check("lu_stl_flag", {31'd0, bus.LoadUseStall}, 32'd1);
        tick();
        check("lu_stl_hold", {31'd0, bus.OutMemRead}, 32'd1);
        check("lu_stl_flag2", {31'd0, bus.LoadUseStall}, 32'd1);
        bus.Stall = 0;
        tick();
        check("lu_stl_bub", {31'd0, bus.OutValid}, 32'd0);

        // Flush with concurrent hazard
        issue_lw(5'd8);
        clear_in();
        bus.InValid = 1; bus.InRt = 5'd8; bus.InRtData = 32'd9; bus.Flush = 1;
        tick();
        check("flush_hz_valid", {31'd0, bus.OutValid}, 32'd0);
        check("flush_hz_lus", {31'd0, bus.LoadUseStall}, 32'd0);

        // Stall holds across three edges
        clear_in();
        bus.InValid = 1; bus.InRsData = 32'h11; bus.InRtData = 32'h22; bus.InRs = 5'd1;
        bus.InRt = 5'd2;
        tick();
        bus.InRsData = 32'h99; bus.InRtData = 32'h88; bus.Stall = 1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("stall_a", bus.A, 32'h11);
            check("stall_b", bus.B, 32'h22);
        end

        // Flush beats Stall
        bus.Flush = 1;
        tick();
        check("fl_st_valid", {31'd0, bus.OutValid}, 32'd0);
        check("fl_st_a", bus.A, 32'd0);
        check("fl_st_b", bus.B, 32'd0);

        // Reset mid-hazard clears everything
        issue_lw(5'd8);
        clear_in();
        bus.InValid = 1; bus.InRt = 5'd8;
        #1;
        check("rst_hz_pre", {31'd0, bus.LoadUseStall}, 32'd1);
        rst = 1;
        tick();
        check("rst_hz_lus", {31'd0, bus.LoadUseStall}, 32'd0);
        check("rst_hz_valid", {31'd0, bus.OutValid}, 32'd0);
        check("rst_hz_memrd", {31'd0, bus.OutMemRead}, 32'd0);
        check("rst_hz_b", bus.B, 32'd0);
        check("rst_hz_wreg", {27'd0, bus.OutWriteReg}, 32'd0);
        rst = 0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end
endmodule
